// File: rtl/etroc2_pll_pkg.sv
// Shared constants for the ETROC2 PLL lock monitor: state codes,
// default widths and the calibration kick length.
package etroc2_pll_pkg;
  localparam int CNTW_DEF = 12;
  localparam int LOLW_DEF = 8;
  localparam int KICK_LEN = 4;

  localparam logic [1:0] ST_KICK   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACQ    = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;
  // LOST shares code 0 with KICK and is told apart by lost_flag
  localparam logic [1:0] ST_LOST   = 2'd0;
endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL phase-match flag
// into the clk40 domain.
module pll_lock_sync (
  input  logic clk40,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic meta;

  always_ff @(posedge clk40) begin
    if (reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end
endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: lock/unlock filtering, relock timeout, loss counter.
// Define PLL_LOCK_MONITOR_HISTORY_EN to build the 8-sample history.
module pll_lock_monitor
  import etroc2_pll_pkg::*;
#(
  parameter int CNTW = CNTW_DEF,
  parameter int LOLW = LOLW_DEF
) (
  input  logic            clk40,
  input  logic            reset,
  input  logic            instantLock,
  input  logic            pllCalibrationDone,
  input  logic [CNTW-1:0] lockThreshold,
  input  logic [CNTW-1:0] unlockThreshold,
  input  logic [CNTW-1:0] relockTimeout,
  input  logic            clearCounters,
  output logic            startCalibration,
  output logic            pllLocked,
  output logic            recalRequest,
  output logic [LOLW-1:0] lossOfLockCount,
  output logic [1:0]      monitorState,
  output logic [7:0]      lockHistory
);
  logic            sample;
  logic [1:0]      state;
  logic            lost_flag;
  logic            lock_pend;
  logic [2:0]      kick_cnt;
  logic [CNTW-1:0] good_cnt, bad_cnt, tmo_cnt;
  logic [CNTW-1:0] good_inc, bad_inc, tmo_inc;
  logic [CNTW-1:0] lock_thr, unlock_thr;
  logic [LOLW-1:0] lol_inc;
  logic            loss_evt, recal_hit;

  pll_lock_sync u_sync (
    .clk40 (clk40),
    .reset (reset),
    .din   (instantLock),
    .dout  (sample)
  );

  assign good_inc = (&good_cnt) ? good_cnt : good_cnt + 1'b1;
  assign bad_inc  = (&bad_cnt)  ? bad_cnt  : bad_cnt + 1'b1;
  assign tmo_inc  = (&tmo_cnt)  ? tmo_cnt  : tmo_cnt + 1'b1;
  assign lol_inc  = (&lossOfLockCount) ? lossOfLockCount
                                       : lossOfLockCount + 1'b1;

  assign lock_thr   = (lockThreshold == '0)   ? CNTW'(1) : lockThreshold;
  assign unlock_thr = (unlockThreshold == '0) ? CNTW'(1) : unlockThreshold;

  assign loss_evt = (state == ST_LOCKED) && pllCalibrationDone &&
                    !sample && (bad_inc >= unlock_thr);
  // Fires once when the count crosses the timeout; 0 never crosses
  assign recal_hit = lost_flag && pllCalibrationDone &&
                     (tmo_cnt < relockTimeout) &&
                     (tmo_inc >= relockTimeout);

  assign pllLocked    = (state == ST_LOCKED);
  assign monitorState = state;

  always_ff @(posedge clk40) begin
    if (reset) begin
      state            <= ST_KICK;
      lost_flag        <= 1'b0;
      lock_pend        <= 1'b0;
      kick_cnt         <= '0;
      startCalibration <= 1'b0;
      good_cnt         <= '0;
      bad_cnt          <= '0;
      tmo_cnt          <= '0;
    end else begin
      startCalibration <= 1'b0;
      if (state == ST_KICK && !lost_flag) begin
        if (kick_cnt == 3'(KICK_LEN)) begin
          state <= ST_IDLE;
        end else begin
          kick_cnt         <= kick_cnt + 1'b1;
          startCalibration <= 1'b1;
        end
      end else if (!pllCalibrationDone) begin
        state     <= ST_IDLE;
        lost_flag <= 1'b0;
        lock_pend <= 1'b0;
        good_cnt  <= '0;
        bad_cnt   <= '0;
        tmo_cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state     <= ST_ACQ;
            good_cnt  <= '0;
            lock_pend <= 1'b0;
          end
          ST_ACQ: begin
            if (lock_pend) begin
              state     <= ST_LOCKED;
              lock_pend <= 1'b0;
              bad_cnt   <= '0;
            end else if (sample) begin
              good_cnt <= good_inc;
              if (good_inc >= lock_thr) lock_pend <= 1'b1;
            end else begin
              good_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (sample) begin
              bad_cnt <= '0;
            end else if (loss_evt) begin
              state     <= ST_LOST;
              lost_flag <= 1'b1;
              bad_cnt   <= '0;
              tmo_cnt   <= '0;
            end else begin
              bad_cnt <= bad_inc;
            end
          end
          default: begin
            tmo_cnt <= tmo_inc;
            if (sample) begin
              state     <= ST_ACQ;
              lost_flag <= 1'b0;
              good_cnt  <= '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      lossOfLockCount <= '0;
      recalRequest    <= 1'b0;
    end else begin
      if (clearCounters)
        lossOfLockCount <= loss_evt ? LOLW'(1) : '0;
      else if (loss_evt)
        lossOfLockCount <= lol_inc;
      if (clearCounters)
        recalRequest <= 1'b0;
      else if (recal_hit)
        recalRequest <= 1'b1;
    end
  end

`ifdef PLL_LOCK_MONITOR_HISTORY_EN
  logic [7:0] hist;
  always_ff @(posedge clk40) begin
    if (reset) hist <= '0;
    else       hist <= {hist[6:0], sample};
  end
  assign lockHistory = hist;
`else
  assign lockHistory = 8'h00;
`endif
endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter CNTW, default 12, width of threshold/timeout inputs and internal run counters.
REQ-002 Parameter LOLW, default 8, width of loss-of-lock event counter.
REQ-003 clk40  input  1  40 MHz recovered clock; the block's only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instantLock  input  1  raw PLL phase-match indicator, asynchronous to clk40.
REQ-006 pllCalibrationDone  input  1  PLL calibration finished (level).
REQ-007 lockThreshold  input  CNTW  consecutive good samples required to declare lock.
REQ-008 unlockThreshold  input  CNTW  consecutive bad samples required to declare loss of lock.
REQ-009 relockTimeout  input  CNTW  cycles in LOST before recalRequest asserts.
REQ-010 clearCounters  input  1  synchronous clear of lossOfLockCount.
REQ-011 startCalibration  output  1  calibration kick to the PLL.
REQ-012 pllLocked  output  1  filtered lock status.
REQ-013 recalRequest  output  1  sticky request to slow control.
REQ-014 lossOfLockCount  output  LOLW  saturating count of LOCKED->LOST transitions.
REQ-015 monitorState  output  2  current FSM state encoding.
REQ-016 lockHistory  output  8  last 8 synchronized samples, bit0 newest.

Function
REQ-017 instantLock SHALL pass a 2-flop synchronizer; "sample" means the second flop output, 2-cycle latency.
REQ-018 FSM states SHALL be KICK=0, IDLE=1, ACQUIRE=2, LOCKED=3 and LOST (encoded 0 with lostFlag), exposed as LOST=0 only when lostFlag set; monitorState shows {KICK|LOST}=0.
REQ-019 KICK: startCalibration SHALL be high exactly 4 cycles after reset release, then go IDLE.
REQ-020 IDLE: when pllCalibrationDone=1 SHALL go ACQUIRE with good-run counter cleared.
REQ-021 ACQUIRE: good sample increments good-run counter, bad sample clears it; when counter+1 >= max(lockThreshold,1) on a good sample SHALL go LOCKED next cycle.
REQ-022 LOCKED: pllLocked=1; bad sample increments bad-run counter, good sample clears it; when counter+1 >= max(unlockThreshold,1) SHALL go LOST and increment lossOfLockCount.
REQ-023 LOST: pllLocked=0; timeout counter increments each cycle; reaching relockTimeout (0 means never) SHALL set recalRequest; a good sample SHALL go ACQUIRE without clearing recalRequest.
REQ-024 pllCalibrationDone falling in ACQUIRE/LOCKED/LOST SHALL return to IDLE, pllLocked=0, no loss counted.
REQ-025 Run and timeout counters SHALL saturate at all-ones.
REQ-026 lossOfLockCount SHALL saturate at 2^LOLW-1; clearCounters with a simultaneous loss event SHALL yield 1.
REQ-027 clearCounters SHALL also clear recalRequest.
REQ-028 Threshold inputs SHALL be sampled live each cycle; changes take effect on the next comparison.

Reset
REQ-029 reset SHALL force KICK, synchronizer flops 0, all counters 0, pllLocked=0, recalRequest=0, lossOfLockCount=0, lockHistory=0, startCalibration=0 during reset.
REQ-030 reset asserted mid-operation SHALL take effect on the next clk40 edge regardless of state.

Configuration
REQ-031 Macro PLL_LOCK_MONITOR_HISTORY_EN defined: lockHistory SHALL be an 8-bit shift register of samples, shifted every cycle.
REQ-032 Macro undefined: lockHistory SHALL be constant 0 and no history flops SHALL exist.

Structure
REQ-033 State encodings, default widths and KICK length (4) SHALL live in shared package etroc2_pll_pkg.
REQ-034 Synchronizer SHALL be sub-module pll_lock_sync (2-flop, reset to 0); counters and FSM stay in top.

Verification
REQ-035 Reset release, pllCalibrationDone=0 -> startCalibration high cycles 1-4, monitorState=IDLE from cycle 5, pllLocked=0.
REQ-036 lockThreshold=10, instantLock=1 steady, pllCalibrationDone=1 -> pllLocked=1 exactly 2+10+1 cycles after ACQUIRE entry.
REQ-037 LOCKED, unlockThreshold=3, instantLock low 2 cycles then high -> stays locked; low 3 cycles -> LOST, lossOfLockCount=1.
REQ-038 LOST, relockTimeout=5, instantLock=0 -> recalRequest=1 after 5 cycles; clearCounters -> recalRequest=0, lossOfLockCount=0.
REQ-039 LOLW=8, force 256 lock losses -> lossOfLockCount holds 255; clearCounters on a loss cycle -> 1.
REQ-040 With PLL_LOCK_MONITOR_HISTORY_EN, pattern 10110010 -> lockHistory=8'b01001101 two cycles later; without macro -> 0.
